fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  PC generation + instruction fetch feeding the control path decoder. Issues in-order word reads to
//  instruction memory, buffers returned words in a small queue, presents {instruction, PC} to decode
//  under valid/ready. Branch/jump redirect from execute flushes the queue and discards in-flight responses.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC of first fetch after reset (word aligned)
//  QUEUE_DEPTH  2              fetch queue entries; power of 2, >=2; also max outstanding+buffered words
// PORTS
//  iClk           in   1   clock
//  iRst           in   1   synchronous reset, active-high
//  oImemReq       out  1   read request valid
//  oImemAddr      out  32  byte address of requested word (PC)
//  iImemGnt       in   1   request accepted this cycle (handshake when oImemReq & iImemGnt)
//  iImemRvalid    in   1   response valid; responses return in order, >=1 cycle after grant
//  iImemRdata     in   32  response instruction word
//  oValid         out  1   oInstruction/oPC valid toward decode
//  iReady         in   1   decode consumes head entry when oValid & iReady
//  oInstruction   out  32  instruction word (drives control path iInstruction)
//  oPC            out  32  PC of oInstruction
//  oPCPlus4       out  32  oPC + 4
//  iRedirect      in   1   taken branch/jump from execute (PCSrc)
//  iRedirectPC    in   32  redirect target
//  oMisalign      out  1   [FETCH_MISALIGN_CHECK_EN only] sticky misaligned-target trap
// BEHAVIOUR
//  - Reset: PC=RESET_PC, queue empty, outstanding=0, drop=0, FSM=IDLE; all outputs 0 (oImemAddr=RESET_PC).
//  - FSM: IDLE -> FETCH one cycle after reset release; FETCH steady state; TRAP only with macro.
//  - Request: oImemReq = (state==FETCH) & (outstanding + count < QUEUE_DEPTH); oImemAddr = PC (registered).
//    On grant: PC <= PC+4 (32-bit wrap, 32'hFFFF_FFFC -> 0), outstanding++.
//  - Credit rule guarantees every response has a queue slot; responses never back-pressured.
//  - Response: outstanding--; if drop>0 -> discard, drop--; else push {rdata, addr-tag} to queue tail.
//    Request addresses kept in a parallel in-flight FIFO (depth QUEUE_DEPTH) to tag PCs.
//  - Output: oValid = queue not empty; head presented combinationally from queue storage; pop on oValid&iReady.
//    Response-to-oValid latency 1 cycle (push registered). No bypass of empty queue.
//  - Simultaneous push+pop when full or empty: both honoured, count unchanged/consistent.
//  - Redirect (highest priority): queue cleared, pop suppressed; PC <= iRedirectPC;
//    drop <= outstanding_next (includes a grant in same cycle, excludes a response in same cycle which
//    is itself discarded). oValid=0 next cycle. First new request issues next cycle.
//  - Redirect while drop>0: drop accumulates correctly (drop = all still-outstanding requests).
//  - iRedirectPC[1:0] ignored (forced 0) when macro off.
//  - Reset mid-operation: all state cleared; stale responses after reset not our concern (memory reset too).
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined: iRedirect with iRedirectPC[1:0]!=0 -> FSM TRAP: queue cleared,
//   oImemReq=0, oValid=0, oMisalign=1 sticky until iRst; outstanding responses still counted/discarded.
//  Undefined: no TRAP state, oMisalign port absent, low bits silently cleared.
// STRUCTURE
//  include/FetchTypeDefs.svh: FetchStates enum {IDLE, FETCH, TRAP}; FetchEntry struct {instr, pc};
//   WORD_BYTES=4 constant. Sub-module fetch_queue (parameterised FIFO: push/pop/flush, count, full/empty)
//   used for both the instruction queue and the in-flight address FIFO.
// TESTING
//  1 Reset, 0-wait memory (gnt=1, rvalid 1 cycle later), iReady=1 -> oPC 0,4,8,... one/cycle after fill;
//    first oValid 3 cycles after reset release.
//  2 iReady=0 for 10 cycles -> exactly QUEUE_DEPTH words buffered, oImemReq drops to 0, no word lost;
//    release -> PCs continue in sequence.
//  3 Two outstanding (pc 0x10,0x14), iRedirect to 0x100 -> both responses discarded, next oPC=0x100.
//  4 Redirect same cycle as grant of 0x20 and response of 0x1C -> neither appears; next oPC=target.
//  5 PC=32'hFFFF_FFFC fetched -> next oImemAddr=0x0.
//  6 (macro) iRedirectPC=0x102 -> oMisalign=1, oImemReq=0, oValid=0 until iRst; reset -> oPC=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the instruction fetch stage
// Contents: FetchStates (FSM encoding), FetchEntry (queued {instr, pc}),
// WORD_BYTES and next_word_pc() (32-bit wrapping PC increment).
// Macro FETCH_MISALIGN_CHECK_EN adds the TRAP state.
package fetch_stage_pkg;

    localparam int WORD_BYTES = 4;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        TRAP  = 2'd2
    } FetchStates;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1
    } FetchStates;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } FetchEntry;

    function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
        return pc + 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small power-of-2 FIFO with push/pop/flush, count and full/empty
// Ports: i_clk, i_rst (sync, active-high), i_push/i_data write tail, i_pop drops head,
// i_flush empties the queue; o_head is the head entry read combinationally from storage,
// o_count/o_full/o_empty report occupancy.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so push+pop on a full queue is honoured.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC generation and in-order instruction fetch feeding decode
// Ports: iClk/iRst (sync, active-high); oImemReq/oImemAddr/iImemGnt request side;
// iImemRvalid/iImemRdata in-order responses; oValid/iReady/oInstruction/oPC/oPCPlus4
// toward decode; iRedirect/iRedirectPC taken branch/jump from execute;
// oMisalign sticky misaligned-target trap (only with FETCH_MISALIGN_CHECK_EN).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    output logic        oImemReq,
    output logic [31:0] oImemAddr,
    input  logic        iImemGnt,
    input  logic        iImemRvalid,
    input  logic [31:0] iImemRdata,
    output logic        oValid,
    input  logic        iReady,
    output logic [31:0] oInstruction,
    output logic [31:0] oPC,
    output logic [31:0] oPCPlus4,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPC
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        oMisalign
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    FetchStates    r_state;
    FetchStates    w_state_next;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_drop;

    logic          w_req;
    logic          w_grant;
    logic          w_misalign_redirect;
    logic [31:0]   w_redirect_pc;
    logic          w_discard;
    logic          w_iq_push;
    logic          w_iq_pop;
    logic          w_iq_flush;
    logic [63:0]   w_iq_head;
    logic [CW-1:0] w_iq_count;
    logic          w_iq_full;
    logic          w_iq_empty;
    logic          w_if_pop;
    logic [31:0]   w_if_head;
    logic [CW-1:0] w_if_count;
    logic          w_if_full;
    logic          w_if_empty;
    logic [CW-1:0] w_outstanding_next;
    FetchEntry     w_head;

    // The in-flight address FIFO occupancy is the outstanding-request count.
    assign w_grant            = w_req & iImemGnt;
    assign w_if_pop           = iImemRvalid & ~w_if_empty;
    assign w_outstanding_next = w_if_count + CW'(w_grant) - CW'(w_if_pop);
    assign w_redirect_pc      = iRedirectPC & ~32'h3;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;
    assign w_misalign_redirect = iRedirect & (iRedirectPC[1:0] != 2'b00);
    assign w_iq_flush          = iRedirect | (r_state == TRAP);
    assign oMisalign           = r_misalign;
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_misalign <= 1'b0;
        end else if (w_misalign_redirect) begin
            r_misalign <= 1'b1;
        end
    end
`else
    assign w_misalign_redirect = 1'b0;
    assign w_iq_flush          = iRedirect;
`endif

    // A response arriving in a redirect cycle belongs to the old path and is
    // excluded from the new drop count, so it must be discarded here.
    assign w_discard = (r_drop != '0) | iRedirect;
    assign w_iq_push = w_if_pop & ~w_discard;
    assign w_iq_pop  = ~w_iq_empty & iReady & ~iRedirect;

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH:   w_req = (({1'b0, w_if_count} + {1'b0, w_iq_count}) < (CW + 1)'(QUEUE_DEPTH))
                             & ~w_iq_full & ~w_if_full;
            default: w_state_next = r_state;
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        if (w_misalign_redirect) begin
            w_state_next = TRAP;
            w_req        = 1'b0;
        end
`endif
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_next;
            if (iRedirect) begin
                r_pc   <= w_redirect_pc;
                r_drop <= w_outstanding_next;
            end else begin
                if (w_grant) begin
                    r_pc <= next_word_pc(r_pc);
                end
                if (w_if_pop && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

    fetch_queue #(.WIDTH(32), .DEPTH(QUEUE_DEPTH)) u_inflight (
        .i_clk   (iClk),
        .i_rst   (iRst),
        .i_push  (w_grant),
        .i_data  (r_pc),
        .i_pop   (w_if_pop),
        .i_flush (1'b0),
        .o_head  (w_if_head),
        .o_count (w_if_count),
        .o_full  (w_if_full),
        .o_empty (w_if_empty)
    );

    fetch_queue #(.WIDTH(64), .DEPTH(QUEUE_DEPTH)) u_instq (
        .i_clk   (iClk),
        .i_rst   (iRst),
        .i_push  (w_iq_push),
        .i_data  ({iImemRdata, w_if_head}),
        .i_pop   (w_iq_pop),
        .i_flush (w_iq_flush),
        .o_head  (w_iq_head),
        .o_count (w_iq_count),
        .o_full  (w_iq_full),
        .o_empty (w_iq_empty)
    );

    assign w_head       = FetchEntry'(w_iq_head);
    assign oImemReq     = w_req;
    assign oImemAddr    = r_pc;
    assign oValid       = ~w_iq_empty;
    // Head fields are zeroed while empty so idle outputs read as 0.
    assign oInstruction = oValid ? w_head.instr : 32'h0;
    assign oPC          = oValid ? w_head.pc : 32'h0;
    assign oPCPlus4     = oValid ? next_word_pc(w_head.pc) : 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage (directed vectors)
module tb_fetch_stage;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemGnt = 1'b1;
    logic        iImemRvalid = 1'b0;
    logic [31:0] iImemRdata = 32'h0;
    logic        oValid;
    logic        iReady = 1'b0;
    logic [31:0] oInstruction;
    logic [31:0] oPC;
    logic [31:0] oPCPlus4;
    logic        iRedirect = 1'b0;
    logic [31:0] iRedirectPC = 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        oMisalign;
`endif

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] mon_exp;
    bit          mem_hold = 1'b0;

    always #5 iClk = ~iClk;

    fetch_stage dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .oImemReq     (oImemReq),
        .oImemAddr    (oImemAddr),
        .iImemGnt     (iImemGnt),
        .iImemRvalid  (iImemRvalid),
        .iImemRdata   (iImemRdata),
        .oValid       (oValid),
        .iReady       (iReady),
        .oInstruction (oInstruction),
        .oPC          (oPC),
        .oPCPlus4     (oPCPlus4),
        .iRedirect    (iRedirect),
        .iRedirectPC  (iRedirectPC)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .oMisalign    (oMisalign)
`endif
    );

    // Memory contents model: every word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'hA5C3_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge iClk);
        #2;
    endtask

    task automatic do_reset();
        cyc(1);
        iRst      = 1'b1;
        iReady    = 1'b0;
        iRedirect = 1'b0;
        mem_hold  = 1'b0;
        exp_q.delete();
        cyc(2);
    endtask

    task automatic release_to(input logic [31:0] pc);
        iRst        = 1'b0;
        iRedirect   = 1'b1;
        iRedirectPC = pc;
        cyc(1);
        iRedirect   = 1'b0;
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 200) begin
            cyc(1);
            b++;
        end
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL %s_drain: %0d words still expected, required 0", name, exp_q.size());
        iReady = 1'b0;
    endtask

    // Memory: handshake sampled mid-cycle, response driven one cycle after the grant.
    always @(negedge iClk) begin
        if (iRst) mem_q.delete();
        else if (oImemReq && iImemGnt) mem_q.push_back(oImemAddr);
    end

    initial begin
        forever begin
            @(posedge iClk);
            #1;
            if (!iRst && !mem_hold && mem_q.size() != 0) begin
                iImemRvalid = 1'b1;
                iImemRdata  = mem_word(mem_q.pop_front());
            end else begin
                iImemRvalid = 1'b0;
                iImemRdata  = 32'h0;
            end
        end
    end

    // Monitor: every word consumed by decode is compared against the scoreboard.
    always @(negedge iClk) begin
        if (!iRst && oValid && iReady && !iRedirect) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_word: got pc %h expected none", oPC);
            end else begin
                mon_exp = exp_q.pop_front();
                check32("pc", oPC, mon_exp);
                check32("instr", oInstruction, mem_word(mon_exp));
                check32("pc_plus4", oPCPlus4, mon_exp + 32'd4);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int  b;
        bit  found;

        // Reset state
        cyc(2);
        check32("rst_valid", {31'b0, oValid}, 32'h0);
        check32("rst_req", {31'b0, oImemReq}, 32'h0);
        check32("rst_addr", oImemAddr, 32'h0);
        check32("rst_pc", oPC, 32'h0);
        check32("rst_instr", oInstruction, 32'h0);
        check32("rst_pc4", oPCPlus4, 32'h0);

        // Sequential fetch from reset, first oValid 3 cycles after release
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
        iReady = 1'b1;
        iRst   = 1'b0;
        @(posedge iClk);
        @(posedge iClk);
        #1;
        check32("t1_valid_early", {31'b0, oValid}, 32'h0);
        @(posedge iClk);
        #1;
        check32("t1_valid_lat3", {31'b0, oValid}, 32'h1);
        #1;

        // Decode stall: queue fills, requests stop, nothing lost
        b = 0;
        while (exp_q.size() > 12 && b < 100) begin
            cyc(1);
            b++;
        end
        iReady = 1'b0;
        cyc(10);
        check32("t2_req_stalled", {31'b0, oImemReq}, 32'h0);
        check32("t2_valid_held", {31'b0, oValid}, 32'h1);
        iReady = 1'b1;
        drain("t1_t2");

        // Two outstanding requests discarded by a redirect
        do_reset();
        mem_hold = 1'b1;
        release_to(32'h10);
        cyc(4);
        check32("t3_credit_stall", {31'b0, oImemReq}, 32'h0);
        check32("t3_pc_after_two", oImemAddr, 32'h18);
        check32("t3_valid_none", {31'b0, oValid}, 32'h0);
        iRedirect   = 1'b1;
        iRedirectPC = 32'h100;
        mem_hold    = 1'b0;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        iReady = 1'b1;
        @(posedge iClk);
        #1;
        check32("t3_valid_after_redir", {31'b0, oValid}, 32'h0);
        check32("t3_addr_after_redir", oImemAddr, 32'h100);
        #1;
        iRedirect = 1'b0;
        drain("t3");

        // Redirect in the same cycle as grant of 0x20 and response of 0x1C
        do_reset();
        iReady = 1'b1;
        release_to(32'h1C);
        cyc(1);
        check32("t4_setup_req", {31'b0, oImemReq}, 32'h1);
        check32("t4_setup_addr", oImemAddr, 32'h20);
        check32("t4_setup_rvalid", {31'b0, iImemRvalid}, 32'h1);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h208);
        iRedirect   = 1'b1;
        iRedirectPC = 32'h200;
        @(posedge iClk);
        #1;
        check32("t4_valid_after_redir", {31'b0, oValid}, 32'h0);
        check32("t4_addr_after_redir", oImemAddr, 32'h200);
        #1;
        iRedirect = 1'b0;
        drain("t4");

        // PC wrap at the top of the address space
        do_reset();
        iReady = 1'b1;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        release_to(32'hFFFF_FFF8);
        found = 1'b0;
        b     = 0;
        while (!found && b < 40) begin
            if (oImemReq && iImemGnt && oImemAddr == 32'hFFFF_FFFC) found = 1'b1;
            else begin
                cyc(1);
                b++;
            end
        end
        if (found) begin
            @(posedge iClk);
            #1;
            check32("t5_wrap_addr", oImemAddr, 32'h0);
            #1;
        end else begin
            n_total++;
            $display("FAIL t5_wrap_grant: grant of FFFFFFFC not seen, required within 40 cycles");
        end
        drain("t5");

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect traps until reset
        do_reset();
        iReady = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        iRst = 1'b0;
        drain("t6_pre");
        iRedirect   = 1'b1;
        iRedirectPC = 32'h102;
        cyc(1);
        iRedirect = 1'b0;
        iReady    = 1'b1;
        cyc(3);
        check32("t6_misalign", {31'b0, oMisalign}, 32'h1);
        check32("t6_req_off", {31'b0, oImemReq}, 32'h0);
        check32("t6_valid_off", {31'b0, oValid}, 32'h0);
        cyc(5);
        check32("t6_misalign_sticky", {31'b0, oMisalign}, 32'h1);
        do_reset();
        check32("t6_misalign_cleared", {31'b0, oMisalign}, 32'h0);
        iReady = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        iRst = 1'b0;
        drain("t6_post");
`else
        // Low target bits are ignored
        do_reset();
        iReady = 1'b1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        release_to(32'h102);
        drain("t6_lowbits");
`endif

        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
